// File: rtl/aes_key_sched_seq.sv
// Sequential AES-128 key schedule: accepts one cipher key and emits round keys 0..10,
// one per output handshake, computing each next key combinationally from the current one.
module aes_key_sched_seq (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy
);
    typedef enum logic {S_IDLE = 1'b0, S_EMIT = 1'b1} state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // rcon depends only on the round being produced, so no separate rcon register
    function automatic logic [7:0] rcon_of(input logic [3:0] rnd);
        logic [7:0] rc;
        rc = 8'h00;
        case (rnd)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    state_t       r_state;
    state_t       w_next_state;
    logic [127:0] r_rk_out;
    logic [3:0]   r_rk_round;
    logic         w_load;
    logic         w_adv;
    logic [3:0]   w_rnd_next;
    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_rot, w_sub, w_t;
    logic [31:0]  w_n0, w_n1, w_n2, w_n3;
    logic [127:0] w_next_key;

    assign w_rnd_next = r_rk_round + 4'd1;
    assign {w_w0, w_w1, w_w2, w_w3} = r_rk_out;
    assign w_rot = {w_w3[23:0], w_w3[31:24]};
    assign w_sub = {SBOX[w_rot[31:24]], SBOX[w_rot[23:16]], SBOX[w_rot[15:8]], SBOX[w_rot[7:0]]};
    assign w_t   = w_sub ^ {rcon_of(w_rnd_next), 24'h0};
    assign w_n0  = w_w0 ^ w_t;
    assign w_n1  = w_w1 ^ w_n0;
    assign w_n2  = w_w2 ^ w_n1;
    assign w_n3  = w_w3 ^ w_n2;
    assign w_next_key = {w_n0, w_n1, w_n2, w_n3};

    always_comb begin
        w_next_state = r_state;
        key_ready    = 1'b0;
        rk_valid     = 1'b0;
        busy         = 1'b0;
        w_load       = 1'b0;
        w_adv        = 1'b0;
        case (r_state)
            S_IDLE: begin
                key_ready = 1'b1;
                if (key_valid) begin
                    w_next_state = S_EMIT;
                    w_load       = 1'b1;
                end
            end
            S_EMIT: begin
                rk_valid = 1'b1;
                busy     = 1'b1;
                if (rk_ready) begin
                    if (r_rk_round == 4'd10) w_next_state = S_IDLE;
                    else                     w_adv        = 1'b1;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rk_out   <= '0;
            r_rk_round <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_load) begin
                r_rk_out   <= key_in;
                r_rk_round <= 4'd0;
            end else if (w_adv) begin
                r_rk_out   <= w_next_key;
                r_rk_round <= w_rnd_next;
            end
        end
    end

    assign rk_out   = r_rk_out;
    assign rk_round = r_rk_round;

endmodule
